scan_mux: RTL and testbench
===========================

Name: scan_mux

Overview:
- Parametrised N_CH-channel, W-bit registered multiplexer with four operating modes: manual select, continuous round-robin scan, hold, and one-shot sweep.
- Successor to the combinational 4:1 mux. Adds a channel-enable mask, a dwell counter and a done pulse.
- Feeds the lab display/capture path, which needs channels presented one at a time at a controlled rate.

Parameters:
- N_CH, 4, number of input channels (>=2).
- W, 1, bit width of each channel.
- DWELL, 1, clock cycles spent on each channel in scan/sweep (>=1).
- SELW, $clog2(N_CH), derived localparam; width of channel index.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- din  in  N_CH*W  packed channel data; channel k at bits [k*W +: W].
- sel  in  SELW  channel index used in manual mode.
- mode  in  2  00 manual, 01 scan, 10 hold, 11 sweep.
- ch_en  in  N_CH  per-channel enable mask for scan/sweep.
- start  in  1  sweep trigger; pulse, sampled only in mode 11.
- out  out  W  registered selected data.
- out_ch  out  SELW  index of channel currently driving out.
- out_valid  out  1  out holds valid channel data.
- done  out  1  one-cycle pulse at sweep completion.

Behaviour:
- Reset (sampled at clk edge): out=0, out_ch=0, out_valid=0, done=0, dwell counter=0, sweep FSM=IDLE. Reset has priority over all inputs and aborts any sweep with no done pulse.
- Latency: all outputs are registered. out at cycle k+1 equals din[out_ch] for out_ch selected at edge k.
- In every active mode except hold: out <= din[next_ch], where next_ch is the value out_ch takes at that edge.
- Manual (00):
  - out_ch <= sel; out_valid <= 1.
  - If sel >= N_CH (non-power-of-2 N_CH): out <= 0, out_valid <= 0, out_ch holds.
  - ch_en is ignored.
- Scan (01):
  - Dwell counter counts 0..DWELL-1 on the current channel.
  - At terminal count, out_ch advances to the next enabled index above it, wrapping N_CH-1 -> 0, and the counter resets.
  - If the current out_ch is disabled in ch_en, advance at the next edge without waiting for dwell.
  - Single enabled channel: stays on it.
  - ch_en == 0: out <= 0, out_valid <= 0, out_ch holds.
  - Otherwise out_valid=1.
  - Entering scan from another mode starts from the current out_ch with the counter cleared.
- Hold (10): out, out_ch, out_valid and the dwell counter are frozen. done=0.
- Sweep (11), FSM states IDLE, RUN, FIN:
  - IDLE:
    - out_valid=0, out holds.
    - start=1 with ch_en!=0: go to RUN; out_ch <= lowest enabled index; counter=0.
    - start with ch_en==0: ignored.
  - RUN:
    - out_valid=1; visit enabled channels in ascending order, DWELL cycles each.
    - At terminal count on the highest enabled index: go to FIN.
    - start while in RUN is ignored.
    - ch_en changes during RUN are honoured at the next advance decision.
  - FIN: done=1 for exactly one cycle; out_valid <= 0; go to IDLE.
  - Leaving mode 11 while in RUN or FIN: FSM returns to IDLE, no done pulse, and the new mode takes effect the same edge.
- done is 0 in every mode other than sweep FIN.
- Arithmetic: the dwell counter is $clog2(DWELL+1) bits wide. The channel index wraps modulo N_CH, with no out-of-range index produced in scan/sweep.

Test Plan:
- Manual, N_CH=4, W=1, din=4'b1101 (i0=1,i1=0,i2=1,i3=1); sel = 3, 2, 1, 0 each held 10 cycles -> out = 1, 1, 0, 1 one cycle after each sel change; out_valid=1; out_ch tracks sel.
- Scan, DWELL=2, ch_en=4'b1111, din=4'b1101 -> out_ch sequence 0,0,1,1,2,2,3,3,0; out = 1,1,0,0,1,1,1,1,1.
- Scan with ch_en=4'b0101 -> out_ch alternates 0,2,0,2 every DWELL cycles. Then set ch_en=0 -> out_valid=0 and out=0 next edge.
- Sweep, DWELL=1, ch_en=4'b1110, start pulse -> out_ch 1,2,3; out_valid=1 for 3 cycles; done=1 on the following cycle only, then out_valid=0. A second start mid-sweep has no effect.
- Hold mid-scan on out_ch=2 for 5 cycles with din toggling -> out and out_ch unchanged. Returning to scan resumes at 2 with full dwell.
- Assert reset during sweep RUN -> next edge: all outputs 0, no done pulse. A later start restarts from the lowest enabled channel.

Source files
------------

// File: rtl/scan_mux.sv
// Registered N_CH:1 channel mux with manual, round-robin scan, hold and one-shot sweep modes.
// Latency 1 cycle (every output is a flop); no backpressure, outputs update each cycle.
module scan_mux #(
    parameter int N_CH  = 4,
    parameter int W     = 1,
    parameter int DWELL = 1,
    localparam int SELW = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH*W-1:0] din,
    input  logic [SELW-1:0]   sel,
    input  logic [1:0]        mode,
    input  logic [N_CH-1:0]   ch_en,
    input  logic              start,
    output logic [W-1:0]      out,
    output logic [SELW-1:0]   out_ch,
    output logic              out_valid,
    output logic              done
);
    localparam int CW = $clog2(DWELL + 1);
    localparam logic [CW-1:0] CNT_TC = CW'(DWELL - 1);

    localparam logic [1:0] MODE_MAN   = 2'b00;
    localparam logic [1:0] MODE_SCAN  = 2'b01;
    localparam logic [1:0] MODE_HOLD  = 2'b10;
    localparam logic [1:0] MODE_SWEEP = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } sweep_state_e;

    logic [W-1:0] din_a [N_CH];

    for (genvar k = 0; k < N_CH; k++) begin : g_unpack
        assign din_a[k] = din[k*W +: W];
    end

    // Next enabled index above cur, wrapping; returns cur when nothing else is enabled.
    function automatic logic [SELW-1:0] next_en(input logic [SELW-1:0] cur,
                                                input logic [N_CH-1:0] en);
        logic [SELW-1:0] r;
        int              idx;
        r = cur;
        for (int i = N_CH - 1; i >= 1; i--) begin
            idx = (int'(cur) + i) % N_CH;
            if (en[idx]) r = SELW'(idx);
        end
        return r;
    endfunction

    function automatic logic [SELW-1:0] lowest_en(input logic [N_CH-1:0] en);
        logic [SELW-1:0] r;
        r = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (en[i]) r = SELW'(i);
        end
        return r;
    endfunction

    function automatic logic has_higher(input logic [SELW-1:0] cur,
                                        input logic [N_CH-1:0] en);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (en[i] && i > int'(cur)) r = 1'b1;
        end
        return r;
    endfunction

    logic [W-1:0]    out_q, out_d;
    logic [SELW-1:0] out_ch_q, out_ch_d;
    logic            out_valid_q, out_valid_d;
    logic            done_q, done_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    sweep_state_e    state_q, state_d;
    logic            scan_act_q, scan_act_d;

    always_comb begin
        out_d       = out_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        cnt_d       = cnt_q;
        state_d     = S_IDLE;
        scan_act_d  = 1'b0;

        case (mode)
            MODE_MAN: begin
                if (int'(sel) >= N_CH) begin
                    out_d       = '0;
                    out_valid_d = 1'b0;
                end else begin
                    out_ch_d    = sel;
                    out_d       = din_a[sel];
                    out_valid_d = 1'b1;
                end
            end

            MODE_SCAN: begin
                scan_act_d = 1'b1;
                if (ch_en == '0) begin
                    out_d       = '0;
                    out_valid_d = 1'b0;
                    cnt_d       = '0;
                end else begin
                    out_valid_d = 1'b1;
                    // The entry edge only clears the counter, so a resumed channel gets a full dwell.
                    if (!ch_en[out_ch_q] || (scan_act_q && cnt_q == CNT_TC)) begin
                        out_ch_d = next_en(out_ch_q, ch_en);
                        cnt_d    = '0;
                    end else if (!scan_act_q) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    out_d = din_a[out_ch_d];
                end
            end

            MODE_HOLD: begin
            end

            MODE_SWEEP: begin
                case (state_q)
                    S_RUN: begin
                        if (cnt_q == CNT_TC) begin
                            cnt_d = '0;
                            if (has_higher(out_ch_q, ch_en)) begin
                                state_d     = S_RUN;
                                out_ch_d    = next_en(out_ch_q, ch_en);
                                out_d       = din_a[out_ch_d];
                                out_valid_d = 1'b1;
                            end else begin
                                state_d     = S_FIN;
                                done_d      = 1'b1;
                                out_valid_d = 1'b0;
                            end
                        end else begin
                            state_d     = S_RUN;
                            cnt_d       = cnt_q + CW'(1);
                            out_d       = din_a[out_ch_q];
                            out_valid_d = 1'b1;
                        end
                    end
                    S_FIN: begin
                        out_valid_d = 1'b0;
                    end
                    default: begin
                        out_valid_d = 1'b0;
                        if (start && ch_en != '0) begin
                            state_d     = S_RUN;
                            out_ch_d    = lowest_en(ch_en);
                            cnt_d       = '0;
                            out_d       = din_a[out_ch_d];
                            out_valid_d = 1'b1;
                        end
                    end
                endcase
            end

            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
            state_q     <= S_IDLE;
            scan_act_q  <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            scan_act_q  <= scan_act_d;
        end
    end

    assign out       = out_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_scan_mux.sv
// Bench for scan_mux: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a behavioural channel-visiting model.
module tb_scan_mux;
    localparam int N_CH  = 4;
    localparam int W     = 1;
    localparam int DWELL = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [N_CH*W-1:0] din = '0;
    logic [1:0]        sel = '0;
    logic [1:0]        mode = 2'b00;
    logic [N_CH-1:0]   ch_en = '1;
    logic              start = 1'b0;
    logic [W-1:0]      out;
    logic [1:0]        out_ch;
    logic              out_valid;
    logic              done;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    scan_mux #(.N_CH(N_CH), .W(W), .DWELL(DWELL)) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .sel       (sel),
        .mode      (mode),
        .ch_en     (ch_en),
        .start     (start),
        .out       (out),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    int         m_ch, m_dw, m_prev, m_phase;   // phase: 0 idle, 1 sweeping, 2 finished
    logic [W-1:0] m_out;
    logic       m_valid, m_done;

    function automatic logic [W-1:0] chan(input int c);
        return din[c*W +: W];
    endfunction

    function automatic int next_above(input int cur, input logic [N_CH-1:0] en);
        int lst[$];
        for (int c = 0; c < N_CH; c++) if (en[c]) lst.push_back(c);
        foreach (lst[j]) if (lst[j] > cur) return lst[j];
        return lst[0];
    endfunction

    function automatic int first_above(input int cur, input logic [N_CH-1:0] en);
        for (int c = cur + 1; c < N_CH; c++) if (en[c]) return c;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_ch = 0; m_dw = 0; m_prev = -1; m_phase = 0;
            m_out = '0; m_valid = 1'b0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (mode != 2'b11) m_phase = 0;
            case (mode)
                2'b00: begin
                    if (int'(sel) < N_CH) begin
                        m_ch = int'(sel); m_out = chan(m_ch); m_valid = 1'b1;
                    end else begin
                        m_out = '0; m_valid = 1'b0;
                    end
                end
                2'b01: begin
                    if (ch_en == '0) begin
                        m_out = '0; m_valid = 1'b0; m_dw = 0;
                    end else begin
                        if (!ch_en[m_ch]) begin
                            m_ch = next_above(m_ch, ch_en); m_dw = 0;
                        end else if (m_prev != 1) begin
                            m_dw = 0;
                        end else begin
                            m_dw++;
                            if (m_dw == DWELL) begin
                                m_ch = next_above(m_ch, ch_en); m_dw = 0;
                            end
                        end
                        m_out = chan(m_ch); m_valid = 1'b1;
                    end
                end
                2'b10: ;
                default: begin
                    if (m_phase == 0) begin
                        m_valid = 1'b0;
                        if (start && ch_en != '0) begin
                            m_phase = 1; m_ch = next_above(-1, ch_en); m_dw = 0;
                            m_out = chan(m_ch); m_valid = 1'b1;
                        end
                    end else if (m_phase == 1) begin
                        if (m_dw + 1 == DWELL) begin
                            m_dw = 0;
                            if (first_above(m_ch, ch_en) >= 0) begin
                                m_ch = first_above(m_ch, ch_en);
                                m_out = chan(m_ch); m_valid = 1'b1;
                            end else begin
                                m_phase = 2; m_done = 1'b1; m_valid = 1'b0;
                            end
                        end else begin
                            m_dw++; m_out = chan(m_ch); m_valid = 1'b1;
                        end
                    end else begin
                        m_phase = 0; m_valid = 1'b0;
                    end
                end
            endcase
            m_prev = int'(mode);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_out", out, m_out);
            check("model_out_ch", out_ch, m_ch);
            check("model_out_valid", out_valid, m_valid);
            check("model_done", done, m_done);
        end
    end

    // ---------------- directed + random stimulus ----------------
    int man_sel[4]   = '{3, 2, 1, 0};
    int man_out[4]   = '{1, 1, 0, 1};
    int scan_ch[9]   = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    int scan_out[9]  = '{1, 1, 0, 0, 1, 1, 1, 1, 1};
    int sw_ch[8]     = '{1, 1, 2, 2, 3, 3, 3, 3};
    int sw_valid[8]  = '{1, 1, 1, 1, 1, 1, 0, 0};
    int sw_done[8]   = '{0, 0, 0, 0, 0, 0, 1, 0};

    initial begin
        logic [W-1:0] held_out;

        step();
        step();
        check("reset_out", out, 0);
        check("reset_out_ch", out_ch, 0);
        check("reset_valid", out_valid, 0);
        check("reset_done", done, 0);
        chk_en = 1'b1;
        reset = 1'b0;

        // Manual select
        din = 4'b1101;
        for (int k = 0; k < 4; k++) begin
            sel = 2'(man_sel[k]);
            step();
            check("manual_out", out, man_out[k]);
            check("manual_out_ch", out_ch, man_sel[k]);
            check("manual_valid", out_valid, 1);
            repeat (9) step();
        end

        // Round-robin scan, all channels enabled
        mode = 2'b01;
        for (int k = 0; k < 9; k++) begin
            step();
            check("scan_out_ch", out_ch, scan_ch[k]);
            check("scan_out", out, scan_out[k]);
        end

        ch_en = 4'b0101;
        for (int k = 0; k < 8; k++) begin
            step();
            check("scan_sparse_ch", (out_ch == 2'd0 || out_ch == 2'd2), 1);
        end
        ch_en = 4'b0000;
        step();
        check("scan_none_valid", out_valid, 0);
        check("scan_none_out", out, 0);

        // Hold mid-scan on channel 2
        ch_en = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            step();
            if (m_ch == 2) break;
        end
        check("hold_setup_ch", out_ch, 2);
        held_out = m_out;
        mode = 2'b10;
        for (int k = 0; k < 5; k++) begin
            din = ~din;
            step();
            check("hold_out_ch", out_ch, 2);
            check("hold_out", out, held_out);
            check("hold_valid", out_valid, 1);
        end
        mode = 2'b01;
        step(); check("resume_ch_a", out_ch, 2);
        step(); check("resume_ch_b", out_ch, 2);
        step(); check("resume_ch_c", out_ch, 3);

        // One-shot sweep with a redundant start mid-run
        mode = 2'b11;
        ch_en = 4'b1110;
        step();
        check("sweep_idle_valid", out_valid, 0);
        for (int k = 0; k < 8; k++) begin
            start = (k == 0 || k == 2);
            step();
            check("sweep_ch", out_ch, sw_ch[k]);
            check("sweep_valid", out_valid, sw_valid[k]);
            check("sweep_done", done, sw_done[k]);
        end
        start = 1'b0;

        // Reset aborts a running sweep
        start = 1'b1; step(); start = 1'b0;
        step();
        reset = 1'b1;
        step();
        check("abort_out", out, 0);
        check("abort_out_ch", out_ch, 0);
        check("abort_valid", out_valid, 0);
        check("abort_done", done, 0);
        reset = 1'b0;
        step();
        check("abort_idle_valid", out_valid, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_ch", out_ch, 1);
        check("restart_valid", out_valid, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(11) == 0) mode = 2'($urandom_range(3));
            if ($urandom_range(9) == 0) ch_en = 4'($urandom);
            start = ($urandom_range(3) == 0);
            sel   = 2'($urandom);
            din   = 4'($urandom);
            reset = ($urandom_range(199) == 0);
            step();
        end
        reset = 1'b0;
        step();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
